fetch_pq: RTL and testbench

Parametrised instruction prefetch queue that replaces the single-word fetch stage between the program counter and the shared memory bus. It keeps up to DEPTH sequential instruction words ahead of the core's program address and issues paged read requests through the bus handshake. On any non-sequential program-counter change it flushes, and it gates interrupt-pending at instruction boundaries.

---
 rtl/pcpu_pkg.sv | 31 +++
 rtl/fetch_pq_if.sv | 27 ++
 rtl/fetch_pq_ring.sv | 53 +++++
 rtl/fetch_pq.sv | 155 +++++++++++++++
 tb/tb_fetch_pq.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pcpu_pkg.sv
// Shared definitions for the prefetch queue: fetch state encoding,
// supported queue depths and the paged bus address width.
package pcpu_pkg;

    localparam logic [2:0] FS_IDLE        = 3'd0;
    localparam logic [2:0] FS_REQ         = 3'd1;
    localparam logic [2:0] FS_WAIT        = 3'd2;
    localparam logic [2:0] FS_DISCARD_REQ = 3'd3;
    localparam logic [2:0] FS_DISCARD     = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE        = FS_IDLE,
        ST_REQ         = FS_REQ,
        ST_WAIT        = FS_WAIT,
        ST_DISCARD_REQ = FS_DISCARD_REQ,
        ST_DISCARD     = FS_DISCARD
    } fetch_state_t;

    localparam int DEPTH_MIN = 2;
    localparam int DEPTH_MAX = 16;

    localparam int ADDR_W_DEF = 16;
    localparam int PAGE_W_DEF = 8;
    localparam int BUS_AW     = PAGE_W_DEF + ADDR_W_DEF;

    // Bus address is the page concatenated above the program address.
    function automatic int bus_aw(input int page_w, input int addr_w);
        return page_w + addr_w;
    endfunction

endpackage

// File: rtl/fetch_pq_if.sv
// Memory bus handshake between the fetch unit (master) and the shared bus.
interface fetch_pq_if #(
    parameter int ADDR_W  = 16,
    parameter int PAGE_W  = 8,
    parameter int INSTR_W = 32
);
    import pcpu_pkg::*;

    logic [bus_aw(PAGE_W, ADDR_W)-1:0] mem_addr;
    logic                              mem_req;
    logic                              addr_mux;
    logic                              mem_busy;
    logic                              mem_cack;
    logic                              mem_ready;
    logic [INSTR_W-1:0]                mem_data;

    modport master (
        output mem_addr, mem_req, addr_mux,
        input  mem_busy, mem_cack, mem_ready, mem_data
    );

    modport slave (
        input  mem_addr, mem_req, addr_mux,
        output mem_busy, mem_cack, mem_ready, mem_data
    );

endinterface

// File: rtl/fetch_pq_ring.sv
// Ring buffer holding prefetched words; head is the word for the current pc.
module fetch_pq_ring
    import pcpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PTR_W = $clog2(DEPTH);
    // Count is sized for the largest supported depth so it never wraps.
    localparam int CNT_W = $clog2(DEPTH_MAX + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    // Pointer and occupancy update; flush wins over push/pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Word storage; contents are don't-care until counted valid.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[tail] <= din;
    end

    assign dout  = mem[head];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/fetch_pq.sv
// Instruction prefetch queue: keeps up to DEPTH sequential words ahead of pc,
// flushes on redirect and gates interrupts at instruction boundaries.
// Optional build macro FETCH_PQ_BYPASS_EN forwards read data straight to
// instr when the queue is empty.
module fetch_pq
    import pcpu_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int PAGE_W  = 8,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc,
    input  logic               pc_redirect,
    input  logic [PAGE_W-1:0]  page,
    input  logic               instr_take,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               irq_in,
    input  logic               irq_en,
    output logic               irq_p,
    fetch_pq_if.master         bus
);
    localparam int BUS_W = bus_aw(PAGE_W, ADDR_W);

    fetch_state_t       state;
    logic               started;
    logic               pending;
    logic               req_q;
    logic               mux_q;
    logic [ADDR_W-1:0]  fa;
    logic [BUS_W-1:0]   addr_q;
    logic               redir;
    logic               issue;
    logic               resp;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic               byp_take;
    logic [INSTR_W-1:0] head;

    // The first edge out of reset behaves like a redirect to pc.
    assign redir = pc_redirect | ~started;
    assign resp  = (state == ST_WAIT) & bus.mem_ready;
    // Only one request is ever in flight, so in IDLE the queue level alone
    // decides whether a slot is free; a redirect empties it.
    assign issue = started & (state == ST_IDLE) & ~bus.mem_busy
                 & (pc_redirect | ~full);

`ifdef FETCH_PQ_BYPASS_EN
    logic byp_hit;
    assign byp_hit     = resp & empty & ~redir;
    assign byp_take    = byp_hit & instr_take;
    assign instr_valid = ~empty | byp_hit;
    assign instr       = !empty ? head : (byp_hit ? bus.mem_data : '0);
`else
    assign byp_take    = 1'b0;
    assign instr_valid = ~empty;
    assign instr       = empty ? '0 : head;
`endif

    // Redirect beats a simultaneous push or take.
    assign push = resp & ~redir & ~byp_take;
    assign pop  = instr_take & ~empty & ~redir;

    fetch_pq_ring #(.DEPTH(DEPTH), .W(INSTR_W)) u_ring (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redir),
        .din   (bus.mem_data),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // Fetch FSM with registered bus outputs and fetch address tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            started <= 1'b0;
            fa      <= '0;
            addr_q  <= '0;
            req_q   <= 1'b0;
            mux_q   <= 1'b0;
        end else begin
            started <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        state  <= ST_REQ;
                        req_q  <= 1'b1;
                        mux_q  <= 1'b1;
                        addr_q <= {page, pc_redirect ? pc : fa};
                    end
                end
                ST_REQ: begin
                    // A pending request is never withdrawn; redirect only
                    // marks its response for discard.
                    if (bus.mem_cack) begin
                        state <= redir ? ST_DISCARD : ST_WAIT;
                        req_q <= 1'b0;
                    end else if (redir) begin
                        state <= ST_DISCARD_REQ;
                    end
                end
                ST_WAIT: begin
                    if (bus.mem_ready) begin
                        state <= ST_IDLE;
                        mux_q <= 1'b0;
                        fa    <= fa + ADDR_W'(1);
                    end else if (redir) begin
                        state <= ST_DISCARD;
                    end
                end
                ST_DISCARD_REQ: begin
                    if (bus.mem_cack) begin
                        state <= ST_DISCARD;
                        req_q <= 1'b0;
                    end
                end
                ST_DISCARD: begin
                    if (bus.mem_ready) begin
                        state <= ST_IDLE;
                        mux_q <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    req_q <= 1'b0;
                    mux_q <= 1'b0;
                end
            endcase
            // Placed last so a redirect overrides the sequential increment.
            if (redir) fa <= pc;
        end
    end

    // Interrupt pending: latched while enabled, dropped on any redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                 pending <= 1'b0;
        else if (pc_redirect)     pending <= 1'b0;
        else if (irq_in & irq_en) pending <= 1'b1;
    end

    assign irq_p        = pending & instr_valid & irq_en;
    assign bus.mem_addr = addr_q;
    assign bus.mem_req  = req_q;
    assign bus.addr_mux = mux_q;

endmodule

// File: tb/tb_fetch_pq.sv
// Bench for fetch_pq: bus responder model, core consumer with a scoreboard
// of expected instruction words, and directed redirect/busy/irq/reset cases.
module tb_fetch_pq;
    import pcpu_pkg::*;

    localparam int AW = 16;
    localparam int PW = 8;
    localparam int IW = 32;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] pc = '0;
    logic          pc_redirect = 1'b0;
    logic [PW-1:0] page = '0;
    logic          instr_take = 1'b0;
    logic [IW-1:0] instr;
    logic          instr_valid;
    logic          irq_in = 1'b0;
    logic          irq_en = 1'b0;
    logic          irq_p;

    always #5 clk = ~clk;

    fetch_pq_if #(.ADDR_W(AW), .PAGE_W(PW), .INSTR_W(IW)) bus_if ();

    fetch_pq #(.ADDR_W(AW), .PAGE_W(PW), .INSTR_W(IW), .DEPTH(DP)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .pc_redirect (pc_redirect),
        .page        (page),
        .instr_take  (instr_take),
        .instr       (instr),
        .instr_valid (instr_valid),
        .irq_in      (irq_in),
        .irq_en      (irq_en),
        .irq_p       (irq_p),
        .bus         (bus_if)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] memf(input logic [23:0] a);
        return {a[7:0] ^ 8'h5A, a};
    endfunction

    // Bus responder: logs each request address, acks after cack_dly cycles,
    // returns data ready_dly cycles after the ack.
    int          cack_dly = 1;
    int          ready_dly = 0;
    int          bst = 0;
    int          wcnt = 0;
    logic [23:0] baddr;
    logic [23:0] req_log[$];

    initial begin
        bus_if.mem_cack  = 1'b0;
        bus_if.mem_ready = 1'b0;
        bus_if.mem_data  = '0;
        forever begin
            @(negedge clk);
            bus_if.mem_cack  = 1'b0;
            bus_if.mem_ready = 1'b0;
            if (!rst) begin
                bst = 0;
            end else if (bst == 0) begin
                if (bus_if.mem_req) begin
                    baddr = bus_if.mem_addr;
                    req_log.push_back(baddr);
                    wcnt = cack_dly - 1;
                    bst  = 1;
                end
            end else if (bst == 1) begin
                if (wcnt == 0) begin
                    chk("addr_stable", 64'(bus_if.mem_addr), 64'(baddr));
                    bus_if.mem_cack = 1'b1;
                    wcnt = ready_dly;
                    bst  = 2;
                end else wcnt--;
            end else begin
                if (wcnt == 0) begin
                    bus_if.mem_ready = 1'b1;
                    bus_if.mem_data  = memf(baddr);
                    bst = 0;
                end else wcnt--;
            end
        end
    end

    // Scoreboard of words the core must see, in order, after each redirect.
    logic [IW-1:0] exp_q[$];
    int            n_taken = 0;
    bit            took = 1'b0;

    task automatic expect_stream(input logic [PW-1:0] pg, input logic [AW-1:0] start);
        logic [AW-1:0] a;
        exp_q.delete();
        for (int k = 0; k < 64; k++) begin
            a = start + AW'(k);
            exp_q.push_back(memf({pg, a}));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (took) begin
            pc   = pc + AW'(1);
            took = 1'b0;
        end
        instr_take = 1'b0;
    endtask

    task automatic core(input int n, input bit take_en);
        for (int i = 0; i < n; i++) begin
            tick();
            if (take_en) begin
                instr_take = 1'b1;
                if (instr_valid) begin
                    took = 1'b1;
                    n_taken++;
                    chk("sb_nonempty", 64'(exp_q.size() > 0), 64'(1));
                    if (exp_q.size() > 0) chk("instr", 64'(instr), 64'(exp_q.pop_front()));
                end
            end
        end
    endtask

    // Drives a redirect at the current negedge; caller has just ticked.
    task automatic redirect(input logic [AW-1:0] tgt);
        pc          = tgt;
        pc_redirect = 1'b1;
        expect_stream(page, tgt);
        tick();
        pc_redirect = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int lim);
        int i = 0;
        while (!instr_valid && i < lim) begin
            tick();
            i++;
        end
        chk(tag, 64'(instr_valid), 64'(1));
    endtask

    task automatic wait_fetch_wait(input string tag, input int lim);
        int i = 0;
        while (!(bus_if.addr_mux && !bus_if.mem_req) && i < lim) begin
            tick();
            i++;
        end
        chk(tag, 64'(bus_if.addr_mux && !bus_if.mem_req), 64'(1));
    endtask

    function automatic logic [23:0] log_at(input int k);
        return (k < req_log.size()) ? req_log[k] : 24'hFFFFFF;
    endfunction

    initial begin
        int n0;
        int nreq;
        int nirq;
        bus_if.mem_busy = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_req",   64'(bus_if.mem_req),  64'(0));
        chk("rst_mux",   64'(bus_if.addr_mux), 64'(0));
        chk("rst_addr",  64'(bus_if.mem_addr), 64'(0));
        chk("rst_valid", 64'(instr_valid),     64'(0));
        chk("rst_instr", 64'(instr),           64'(0));
        chk("rst_irq",   64'(irq_p),           64'(0));

        // release at pc=0x10, fill to full with no takes
        page = 8'h00;
        pc   = 16'h0010;
        expect_stream(8'h00, 16'h0010);
        rst = 1'b1;
        core(40, 1'b0);
        chk("fill_nreq", 64'(req_log.size()), 64'(4));
        for (int k = 0; k < 4; k++) chk("fill_addr", 64'(log_at(k)), 64'(24'h000010 + 24'(k)));
        chk("full_valid", 64'(instr_valid), 64'(1));
        chk("full_head",  64'(instr), 64'(memf(24'h000010)));
        chk("full_noreq", 64'(bus_if.mem_req), 64'(0));

        // take every cycle, 2-cycle memory
        ready_dly = 1;
        n0 = n_taken;
        core(80, 1'b1);
        chk("stream_progress", 64'(n_taken - n0 >= 8), 64'(1));

        // redirect while waiting for read data
        ready_dly = 2;
        tick();
        wait_fetch_wait("reach_wait", 50);
        n0 = req_log.size();
        redirect(16'h0200);
        chk("redir_flush", 64'(instr_valid), 64'(0));
        wait_valid("redir_valid", 50);
        chk("redir_word", 64'(instr), 64'(memf({page, 16'h0200})));
        chk("redir_addr", 64'(log_at(n0)), 64'({page, 16'h0200}));
        core(20, 1'b1);

        // address wrap inside page 0x03
        ready_dly = 0;
        core(30, 1'b0);
        page = 8'h03;
        tick();
        n0 = req_log.size();
        redirect(16'hFFFE);
        core(60, 1'b1);
        chk("wrap_a0", 64'(log_at(n0)),     64'(24'h03FFFE));
        chk("wrap_a1", 64'(log_at(n0 + 1)), 64'(24'h03FFFF));
        chk("wrap_a2", 64'(log_at(n0 + 2)), 64'(24'h030000));

        // bus busy while empty; takes on empty queue are ignored
        core(30, 1'b0);
        bus_if.mem_busy = 1'b1;
        tick();
        redirect(16'h0500);
        nreq = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            instr_take = 1'b1;
            nreq += int'(bus_if.mem_req);
        end
        chk("busy_noreq", 64'(nreq), 64'(0));
        chk("busy_empty", 64'(instr_valid), 64'(0));
        tick();
        bus_if.mem_busy = 1'b0;
        tick();
        chk("issue_after_busy", 64'(bus_if.mem_req), 64'(1));
        n0 = n_taken;
        core(40, 1'b1);
        chk("busy_progress", 64'(n_taken > n0), 64'(1));

        // irq latched while empty, visible at first valid word
        core(30, 1'b0);
        irq_en = 1'b1;
        bus_if.mem_busy = 1'b1;
        tick();
        redirect(16'h0300);
        tick();
        irq_in = 1'b1;
        tick();
        irq_in = 1'b0;
        chk("irq_gated", 64'(irq_p), 64'(0));
        bus_if.mem_busy = 1'b0;
        wait_valid("irq_valid", 50);
        chk("irq_p_set", 64'(irq_p), 64'(1));
        chk("irq_head",  64'(instr), 64'(memf({page, 16'h0300})));
        tick();
        redirect(16'h0310);
        wait_valid("irq_valid2", 50);
        chk("irq_p_clear", 64'(irq_p), 64'(0));

        // irq ignored while disabled
        core(30, 1'b0);
        irq_en = 1'b0;
        bus_if.mem_busy = 1'b1;
        tick();
        redirect(16'h0320);
        tick();
        irq_in = 1'b1;
        tick();
        irq_in = 1'b0;
        bus_if.mem_busy = 1'b0;
        nirq = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            nirq += int'(irq_p);
        end
        chk("irq_dis", 64'(nirq), 64'(0));
        irq_en = 1'b1;
        tick();
        chk("irq_late_valid", 64'(instr_valid), 64'(1));
        chk("irq_late", 64'(irq_p), 64'(0));

        // reset in the middle of a read
        tick();
        redirect(16'h0600);
        wait_fetch_wait("rst_reach_wait", 50);
        rst = 1'b0;
        tick();
        chk("mid_rst_req",   64'(bus_if.mem_req),  64'(0));
        chk("mid_rst_mux",   64'(bus_if.addr_mux), 64'(0));
        chk("mid_rst_valid", 64'(instr_valid),     64'(0));
        chk("mid_rst_irq",   64'(irq_p),           64'(0));
        page = 8'h00;
        pc   = 16'h0700;
        expect_stream(8'h00, 16'h0700);
        rst = 1'b1;
        n0 = n_taken;
        core(40, 1'b1);
        chk("post_rst_progress", 64'(n_taken > n0), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
